div: RTL
========

// Module: div
// PURPOSE
//  Multi-cycle 32-bit integer divider, the responder to the EX stage for DIV/DIVU.
//  EX drives operands and start_i; div runs a 32-iteration shift-subtract loop, then
//  returns {remainder,quotient}, which EX writes to {HI,LO} via whilo.
//  EX holds start_i and stalls the pipeline until ready_o is seen.
// PARAMETERS
//  DATA_W   32  operand width; result_o is 2*DATA_W; iteration count = DATA_W
//  CNT_W    6   iteration counter width, must hold DATA_W
// PORTS
//  clk           in   1         rising-edge clock
//  rst           in   1         reset, synchronous, active-high
//  signed_div_i  in   1         1 = DIV (signed), 0 = DIVU
//  opdata1_i     in   DATA_W    dividend
//  opdata2_i     in   DATA_W    divisor
//  start_i       in   1         request; held high by EX until ready_o seen
//  annul_i       in   1         cancel in-flight op (branch/exception flush)
//  result_o      out  2*DATA_W  {remainder, quotient}, valid while ready_o=1
//  ready_o       out  1         result valid
// BEHAVIOUR
//  - All outputs registered. On rst: state=FREE, ready_o=0, result_o=0, counter=0.
//  - States: FREE, BYZERO, ON, END.
//  - FREE: start_i=1 & annul_i=0 at edge E0:
//      divisor==0 -> BYZERO; else -> ON, counter=0.
//      Load abs values: if signed_div_i, negate each operand whose MSB is 1 (2's complement).
//      Latch signed_div_i and both operand sign bits internally.
//      Otherwise remain FREE, outputs 0.
//  - BYZERO: next edge -> END, result_o=0, ready_o=1.
//  - ON: one iteration per edge.
//      Partial remainder P (DATA_W+1 bits) = {P[DATA_W-1:0], next dividend MSB}.
//      If P >= divisor: P -= divisor, quotient bit = 1; else quotient bit = 0.
//      Counter increments each iteration.
//      On the edge completing iteration DATA_W (E32): apply sign fix-up, register result_o, ready_o=1, -> END.
//      Net: ready_o=1 after 33 edges counting E0.
//  - Sign fix-up (signed only):
//      quotient negated if dividend and divisor signs differ (truncate toward zero);
//      remainder negated if dividend negative (remainder takes the dividend's sign).
//      Unsigned: no fix-up.
//  - END: hold result_o and ready_o while start_i=1.
//      start_i=0 at edge -> FREE, ready_o=0, result_o=0.
//      Back-to-back ops therefore need >=1 cycle with start_i low.
//  - annul_i=1 in ON or BYZERO: next edge -> FREE, ready_o=0, result_o=0, no result produced.
//      annul_i in END: same as start_i=0.
//      annul_i wins over start_i in every state.
//  - Operand inputs may change after E0; only latched copies are used.
//  - rst mid-operation: abort immediately; reset values on that edge.
//  - Overflow case 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0; no trap.
// STRUCTURE
//  - State encodings DivFree/DivByZero/DivOn/DivEnd (2'b00..2'b11), DivStart/DivStop,
//    DivResultReady/DivResultNotReady and DivCntEnd belong in shared define.v with
//    the other Exe*/Aluop constants.
//  - Optional sub-module div_step: combinational compare/subtract for one iteration.
//  - FSM, counter and datapath registers stay in div.
// TESTING
//  1. DIVU 100/7: ready_o after 33 edges; result_o = {32'd2, 32'd14}; ready_o low cycle after start_i drops.
//  2. DIV -7/2 (0xFFFFFFF9/0x2): result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}; 7/-2: {32'h1, 32'hFFFFFFFD}.
//  3. Divide by zero (any dividend, divisor 0): ready_o after 2 edges, result_o = 64'h0.
//  4. Signed 0x80000000/0xFFFFFFFF: {32'h0, 32'h80000000}; unsigned 0xFFFFFFFF/0x1: {32'h0, 32'hFFFFFFFF}.
//  5. annul_i pulsed at iteration 10: FREE next edge, ready_o never rises;
//     a new start 2 cycles later gives 200/10 = {0, 20} correctly.
//  6. rst asserted at iteration 20 with start_i still high:
//     outputs 0 on the next edge; after rst release, operation restarts from FREE.
//     Operands changed after E0 do not affect the result.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle divider: FSM encodings and handshake levels.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Last counter value for a 32-bit divide; the top derives its own from DATA_W.
  localparam int   DivCntEnd         = 31;

endpackage

// File: rtl/div_step.sv
// One shift-subtract iteration: bring in the next dividend bit, subtract the
// divisor if it fits and report the resulting quotient bit.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              bit_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              q_bit
);

  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;

  // The partial remainder is always below the divisor, so the shifted value
  // needs one extra bit but the difference fits back in DATA_W bits.
  always_comb begin
    shifted  = {rem, bit_in};
    q_bit    = (shifted >= {1'b0, divisor});
    diff     = shifted[DATA_W-1:0] - divisor;
    rem_next = q_bit ? diff : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/div.sv
// Multi-cycle integer divider serving the EX stage for DIV/DIVU.
// Returns {remainder, quotient} with truncation toward zero for signed ops.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DATA_W - 1);

  div_state_e               state, state_d;
  logic [CNT_W-1:0]         cnt;
  logic                     ready_d;
  logic [2*DATA_W-1:0]      result_d;
  logic                     load, iterate;

  logic [DATA_W-1:0]        dividend_q;
  logic [DATA_W-1:0]        divisor_q;
  logic [DATA_W-1:0]        rem_q;
  logic                     sgn_q, s1_q, s2_q;

  logic [DATA_W-1:0]        rem_next;
  logic                     q_bit;
  logic [DATA_W-1:0]        quo_raw;
  logic [DATA_W-1:0]        quo_fix, rem_fix;

  // Two's-complement negate when enabled; the most negative value maps to itself.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic en);
    logic signed [DATA_W-1:0] sv;
    sv = signed'(v);
    return en ? unsigned'(-sv) : v;
  endfunction

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem      (rem_q),
    .bit_in   (dividend_q[DATA_W-1]),
    .divisor  (divisor_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Final quotient/remainder with sign restoration for signed divides.
  always_comb begin
    quo_raw = {dividend_q[DATA_W-2:0], q_bit};
    quo_fix = neg_if(quo_raw, sgn_q & (s1_q ^ s2_q));
    rem_fix = neg_if(rem_next, sgn_q & s1_q);
  end

  // Next-state and registered-output values; annul_i overrides start_i everywhere.
  always_comb begin
    state_d  = state;
    ready_d  = DivResultNotReady;
    result_d = '0;
    load     = 1'b0;
    iterate  = 1'b0;
    case (state)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          load    = 1'b1;
          state_d = (opdata2_i == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          state_d = DivEnd;
          ready_d = DivResultReady;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          iterate = 1'b1;
          if (cnt == CNT_END) begin
            state_d  = DivEnd;
            ready_d  = DivResultReady;
            result_d = {rem_fix, quo_fix};
          end
        end
      end
      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          state_d = DivFree;
        end else begin
          ready_d  = DivResultReady;
          result_d = result_o;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  // Control state, counter and outputs; cleared by rst on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DivFree;
      cnt      <= '0;
      ready_o  <= DivResultNotReady;
      result_o <= '0;
    end else begin
      state    <= state_d;
      ready_o  <= ready_d;
      result_o <= result_d;
      if (load)         cnt <= '0;
      else if (iterate) cnt <= cnt + 1'b1;
    end
  end

  // Working datapath: latched magnitudes at start, then one shift-subtract per cycle.
  always_ff @(posedge clk) begin
    if (load) begin
      dividend_q <= neg_if(opdata1_i, signed_div_i & opdata1_i[DATA_W-1]);
      divisor_q  <= neg_if(opdata2_i, signed_div_i & opdata2_i[DATA_W-1]);
      rem_q      <= '0;
      sgn_q      <= signed_div_i;
      s1_q       <= opdata1_i[DATA_W-1];
      s2_q       <= opdata2_i[DATA_W-1];
    end else if (iterate) begin
      dividend_q <= quo_raw;
      rem_q      <= rem_next;
    end
  end

endmodule
